// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - sums groups of up to N_TERMS multiplier products over valid/ready
// Optional build macro SATURATE_EN: clamp the group sum at 2^ACC_W-1 instead of wrapping.
module product_accumulator #(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       p,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  input  logic             clear,
  output logic [ACC_W-1:0] sum,
  output logic [3:0]       count,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] DONE  = 1'b1;

  logic [0:0]       state;
  logic [ACC_W-1:0] acc;
  logic [3:0]       cnt;
  logic             ovf;

  logic [ACC_W:0]   add_w;
  logic [ACC_W-1:0] acc_next;
  logic             carry;
  logic [4:0]       cnt_inc;
  logic             final_beat;
  logic             accept;

  always_comb begin
    add_w    = {1'b0, acc} + {{(ACC_W-5){1'b0}}, p};
    carry    = add_w[ACC_W];
`ifdef SATURATE_EN
    // Once clamped, any further nonzero add carries again, so the clamp holds.
    acc_next = carry ? {ACC_W{1'b1}} : add_w[ACC_W-1:0];
`else
    acc_next = add_w[ACC_W-1:0];
`endif
    cnt_inc    = {1'b0, cnt} + 5'd1;
    final_beat = in_last || (cnt_inc == 5'(N_TERMS));
    accept     = in_valid && (state == ACCUM);
  end

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ACCUM;
      acc      <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      sum      <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      // A beat offered alongside clear is handshaken but dropped.
      state <= ACCUM;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else if (state == ACCUM) begin
      if (accept) begin
        acc <= acc_next;
        cnt <= cnt_inc[3:0];
        ovf <= ovf | carry;
        if (final_beat) begin
          sum      <= acc_next;
          count    <= cnt_inc[3:0];
          overflow <= ovf | carry;
          state    <= DONE;
        end
      end
    end else begin
      if (out_ready) begin
        acc   <= '0;
        cnt   <= '0;
        ovf   <= 1'b0;
        state <= ACCUM;
      end
    end
  end

endmodule
